vga_write_arbiter: RTL and testbench

//  Shares the single text-mode VGA tile-memory write port (vga_addr/vga_we/vga_data)

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_write_arbiter_rr_arbiter.sv | 35 +++
 rtl/vga_write_arbiter.sv | 120 ++++++++++++
 tb/tb_vga_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the text-mode VGA tile screen: geometry, word
// widths, tile codes and the write-arbiter state type.
package vga_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    // Tile codes (low byte of a tile word; the high byte is the attribute).
    localparam logic [7:0] TILE_BLANK     = 8'h00;
    localparam logic [7:0] TILE_PAC_R     = 8'h01;
    localparam logic [7:0] TILE_PAC_L     = 8'h02;
    localparam logic [7:0] TILE_PAC_U     = 8'h03;
    localparam logic [7:0] TILE_PAC_D     = 8'h04;
    localparam logic [7:0] TILE_GHOST_0   = 8'h10;
    localparam logic [7:0] TILE_GHOST_1   = 8'h11;
    localparam logic [7:0] TILE_GHOST_2   = 8'h12;
    localparam logic [7:0] TILE_GHOST_3   = 8'h13;
    localparam logic [7:0] TILE_GHOST_FRT = 8'h14;

    // CLEAR: blanking sweep after reset; RUN: normal round-robin granting.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    // Builds a tile word from an attribute byte and a tile code.
    function automatic logic [DATA_W-1:0] tile_word(input logic [7:0] attr,
                                                    input logic [7:0] tile);
        return {attr, tile};
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester found
// searching upward from the one after rr_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    // Scan rr_ptr+1 .. rr_ptr+N; rr_ptr < N so one subtraction wraps the index.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA tile-memory write port between N_REQ
// drawing FSMs, one registered write per cycle.
// Define VGA_ARB_CLEAR_EN to blank all CELLS tiles after reset before any
// requester is granted; without it the arbiter comes out of reset in RUN.
module vga_write_arbiter #(
    parameter int               N_REQ      = 4,
    parameter int               ADDR_W     = 12,
    parameter int               DATA_W     = 16,
    parameter int               CELLS      = 2400,
    parameter logic [DATA_W-1:0] CLEAR_TILE = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [ADDR_W-1:0]       vga_addr,
    output logic                    vga_we,
    output logic [DATA_W-1:0]       vga_data,
    output logic                    busy,
    output logic                    oob_err
);

    import vga_pkg::*;

    localparam int                PTR_W     = $clog2(N_REQ);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    // Handshake: req[i] with its addr/data slice is held until ack[i] pulses
    // for one cycle, which is the cycle the write sits on the vga_* port.
    // A requester being acked is masked for that cycle so a held request is
    // not granted twice for the same write.

    arb_state_t        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
`ifdef VGA_ARB_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
`endif

    assign eligible = req & ~ack;
    assign win_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign win_data = req_data[grant_idx*DATA_W +: DATA_W];

`ifdef VGA_ARB_CLEAR_EN
    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // State, clear sweep, round-robin pointer and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_addr <= '0;
            vga_we   <= 1'b0;
            vga_data <= '0;
            ack      <= '0;
            oob_err  <= 1'b0;
            rr_ptr   <= PTR_W'(N_REQ - 1);
`ifdef VGA_ARB_CLEAR_EN
            state    <= CLEAR;
            clr_addr <= '0;
`else
            state    <= RUN;
`endif
        end else begin
            case (state)
                CLEAR: begin
`ifdef VGA_ARB_CLEAR_EN
                    vga_we   <= 1'b1;
                    vga_addr <= clr_addr;
                    vga_data <= CLEAR_TILE;
                    ack      <= '0;
                    if (clr_addr == LAST_CELL) begin
                        state <= RUN;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
`else
                    state <= RUN;
`endif
                end
                default: begin
                    if (grant_valid) begin
                        ack      <= grant;
                        vga_addr <= win_addr;
                        vga_data <= win_data;
                        rr_ptr   <= grant_idx;
                        // Out-of-screen addresses are acked but never written.
                        vga_we   <= (win_addr <= LAST_CELL);
                        if (win_addr > LAST_CELL) begin
                            oob_err <= 1'b1;
                        end
                    end else begin
                        ack    <= '0;
                        vga_we <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed scenarios followed by random
// requester traffic, checked against a cycle-level reference model.
// Compile with VGA_ARB_CLEAR_EN defined to include the clear-sweep scenarios.
module tb_vga_write_arbiter;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int CELLS = 2400;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [AW-1:0]   vga_addr;
    logic            vga_we;
    logic [DW-1:0]   vga_data;
    logic            busy;
    logic            oob_err;

    always #5 clk = ~clk;

    vga_write_arbiter #(
        .N_REQ      (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .CELLS      (CELLS),
        .CLEAR_TILE (16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .vga_addr (vga_addr),
        .vga_we   (vga_we),
        .vga_data (vga_data),
        .busy     (busy),
        .oob_err  (oob_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected tile writes in order, {addr, data}.
    logic [AW+DW-1:0] exp_q[$];

    // Requester stimulus state.
    logic          t_req [N];
    logic [AW-1:0] t_addr[N];
    logic [DW-1:0] t_data[N];

    // Reference model: last granted requester and expected outputs after the next edge.
    int            m_rr;
    logic [N-1:0]  e_ack;
    logic          e_we;
    logic          e_oob;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]             = t_req[i];
            req_addr[i*AW +: AW] = t_addr[i];
            req_data[i*DW +: DW] = t_data[i];
        end
    endtask

    // Apply stimulus and work out what the port shows after the coming edge.
    task automatic predict();
        int winner;
        drive();
        winner = -1;
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (m_rr + off) % N;
            if (winner < 0 && t_req[i] && !e_ack[i]) winner = i;
        end
        e_ack = '0;
        if (winner >= 0) begin
            e_ack[winner] = 1'b1;
            e_addr = t_addr[winner];
            e_data = t_data[winner];
            e_we   = (int'(t_addr[winner]) < CELLS);
            if (!e_we) e_oob = 1'b1;
            m_rr = winner;
            if (e_we) exp_q.push_back({e_addr, e_data});
        end else begin
            e_we = 1'b0;
        end
    endtask

    task automatic step();
        logic [AW+DW-1:0] w;
        @(posedge clk);
        #1;
        check("ack", ack, e_ack);
        check("we", vga_we, e_we);
        check("addr", vga_addr, e_addr);
        check("data", vga_data, e_data);
        check("oob", oob_err, e_oob);
        check("busy_run", busy, 0);
        if (vga_we) begin
            if (exp_q.size() == 0) begin
                check("write_q_nonempty", exp_q.size(), 1);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", vga_addr, w[AW+DW-1:DW]);
                check("wr_data", vga_data, w[DW-1:0]);
            end
        end
    endtask

    task automatic new_txn(input int i, input bit allow_oob);
        if (allow_oob && $urandom_range(0, 15) == 0)
            t_addr[i] = AW'($urandom_range(CELLS, 4095));
        else
            t_addr[i] = AW'($urandom_range(0, CELLS - 1));
        t_data[i] = DW'($urandom);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            t_req[i]  = 1'b0;
            t_addr[i] = '0;
            t_data[i] = '0;
        end
    endtask

`ifdef VGA_ARB_CLEAR_EN
    task automatic sweep_check(input int n_cycles);
        for (int j = 0; j < n_cycles; j++) begin
            @(posedge clk);
            #1;
            check("clr_we", vga_we, 1);
            check("clr_addr", vga_addr, j);
            check("clr_data", vga_data, 16'h0000);
            check("clr_ack", ack, 0);
            check("clr_busy", busy, (j < CELLS - 1) ? 1 : 0);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_all();
        drive();
        #12;
        check("rst_we", vga_we, 0);
        check("rst_addr", vga_addr, 0);
        check("rst_data", vga_data, 0);
        check("rst_ack", ack, 0);
        check("rst_oob", oob_err, 0);
`ifdef VGA_ARB_CLEAR_EN
        check("rst_busy", busy, 1);
        // Partial sweep, then reset in the middle of it.
        @(negedge clk);
        rst = 1'b0;
        sweep_check(1001);
        #2;
        rst = 1'b1;
        #1;
        check("midclr_we", vga_we, 0);
        check("midclr_addr", vga_addr, 0);
        check("midclr_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        // Full sweep restarting from address 0.
        sweep_check(CELLS);
        e_addr = AW'(CELLS - 1);
`else
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        e_addr = '0;
`endif
        m_rr  = N - 1;
        e_ack = '0;
        e_we  = 1'b0;
        e_oob = 1'b0;
        e_data = '0;
        predict();
        step();

        // Lone requester holding its request: written every other cycle.
        t_req[0] = 1'b1; t_addr[0] = 12'd810; t_data[0] = 16'h0e01;
        predict();
        step();
        check("t2_first_addr", vga_addr, 810);
        check("t2_first_ack", ack, 4'b0001);
        for (int c = 0; c < 6; c++) begin predict(); step(); end
        t_req[0] = 1'b0;
        predict(); step();
        predict(); step();

        // All four held: strict rotation, one write per cycle.
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b1; t_addr[i] = AW'(100 * (i + 1)); t_data[i] = DW'(16'ha000 + i);
        end
        for (int c = 0; c < 9; c++) begin predict(); step(); end
        clear_all();
        predict(); step();

        // Pointer parked on requester 1, then 1 and 3 compete: 3 goes first.
        t_req[1] = 1'b1; t_addr[1] = 12'd5; t_data[1] = 16'h1111;
        predict(); step();
        t_req[1] = 1'b0;
        predict(); step();
        t_req[1] = 1'b1; t_addr[1] = 12'd6;  t_data[1] = 16'h2222;
        t_req[3] = 1'b1; t_addr[3] = 12'd77; t_data[3] = 16'h3333;
        predict(); step();
        check("t6_first_ack", ack, 4'b1000);
        check("t6_first_addr", vga_addr, 77);
        t_req[3] = 1'b0;
        predict(); step();
        check("t6_second_ack", ack, 4'b0010);
        check("t6_second_addr", vga_addr, 6);
        clear_all();
        predict(); step();

        // Out-of-screen address: acked, not written, sticky error.
        t_req[2] = 1'b1; t_addr[2] = 12'd2400; t_data[2] = 16'hbeef;
        predict(); step();
        check("t4_oob_we", vga_we, 0);
        check("t4_oob_ack", ack, 4'b0100);
        check("t4_oob_flag", oob_err, 1);
        t_req[2] = 1'b0;
        t_req[0] = 1'b1; t_addr[0] = 12'd2399; t_data[0] = 16'h0707;
        predict(); step();
        check("t4_edge_we", vga_we, 1);
        check("t4_oob_sticky", oob_err, 1);
        t_req[0] = 1'b0;
        predict(); step();

        // Random requester traffic obeying the hold-until-ack rule.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (t_req[i] && e_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) t_req[i] = 1'b0;
                    else new_txn(i, 1'b1);
                end else if (!t_req[i] && $urandom_range(0, 2) == 0) begin
                    t_req[i] = 1'b1;
                    new_txn(i, 1'b1);
                end
            end
            predict();
            step();
        end
        clear_all();
        predict(); step();
        predict(); step();
        check("q_drained", exp_q.size(), 0);

        // Reset in the middle of normal operation.
        #2;
        rst = 1'b1;
        #1;
        check("midrun_we", vga_we, 0);
        check("midrun_addr", vga_addr, 0);
        check("midrun_ack", ack, 0);
        check("midrun_oob", oob_err, 0);
`ifdef VGA_ARB_CLEAR_EN
        check("midrun_busy", busy, 1);
`else
        check("midrun_busy", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
